// File: rtl/moving_average_mc.sv
// moving_average_mc: multi-channel boxcar filter with run-time window 2^k.
// Pipeline: s0 input reg, s1 state/oldest read, then sum update + output reg.
module moving_average_mc #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int MAX_LOG2_LEN = 3,
  parameter int ROUND        = 1,
  parameter int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int ACC_WIDTH    = DATA_WIDTH + MAX_LOG2_LEN
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic [$clog2(MAX_LOG2_LEN+1)-1:0]    i_log2_len,
  input  logic                                 i_clear,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [CH_WIDTH-1:0]                  i_channel,
  input  logic signed [DATA_WIDTH-1:0]         i_data,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [CH_WIDTH-1:0]                  o_channel,
  output logic signed [ACC_WIDTH-1:0]          o_sum,
  output logic signed [DATA_WIDTH-1:0]         o_data,
  output logic                                 o_full
);
  localparam int LW    = $clog2(MAX_LOG2_LEN + 1);
  localparam int PW    = (MAX_LOG2_LEN > 0) ? MAX_LOG2_LEN : 1;
  localparam int CW    = MAX_LOG2_LEN + 1;
  localparam int DEPTH = 1 << MAX_LOG2_LEN;
  localparam int DMAX  = (1 << (DATA_WIDTH - 1)) - 1;
  localparam int DMIN  = -(1 << (DATA_WIDTH - 1));

  logic [LW-1:0]                k_q, k_sat;
  logic signed [ACC_WIDTH-1:0]  acc_q [NUM_CHANNELS];
  logic [PW-1:0]                ptr_q [NUM_CHANNELS];
  logic [CW-1:0]                cnt_q [NUM_CHANNELS];
  logic signed [DATA_WIDTH-1:0] mem_q [NUM_CHANNELS][DEPTH];

  logic                         s0_v_q;
  logic [CH_WIDTH-1:0]          s0_ch_q;
  logic signed [DATA_WIDTH-1:0] s0_x_q;

  logic                         s1_v_q, s1_stale_q;
  logic [CH_WIDTH-1:0]          s1_ch_q;
  logic signed [DATA_WIDTH-1:0] s1_x_q, s1_old_q;
  logic signed [ACC_WIDTH-1:0]  s1_acc_q;
  logic [PW-1:0]                s1_ptr_q;
  logic [CW-1:0]                s1_cnt_q;
  logic [LW-1:0]                s1_k_q;

  logic                         ov_q, ofull_q;
  logic [CH_WIDTH-1:0]          och_q;
  logic signed [ACC_WIDTH-1:0]  osum_q;
  logic signed [DATA_WIDTH-1:0] odata_q;

  logic adv, flush, accept, ch_ok, wr, fwd, full_b;
  logic [CW-1:0]                len_c, cnt_new, rd_cnt;
  logic [PW-1:0]                mask_c, ptr_new, rd_ptr;
  logic signed [ACC_WIDTH-1:0]  acc_new, x_ext, old_ext, rd_acc;
  logic signed [ACC_WIDTH:0]    rnd_w, avg_w;
  logic signed [DATA_WIDTH-1:0] avg_sat, rd_old;

  assign k_sat  = (i_log2_len > LW'(MAX_LOG2_LEN)) ?
                  LW'(MAX_LOG2_LEN) : i_log2_len;
  assign flush  = i_clear || (k_sat != k_q);
  assign adv    = !ov_q || i_ready;
  assign o_ready = i_reset_n && adv && !flush;
  assign accept = i_valid && o_ready;
  assign ch_ok  = ({1'b0, i_channel} < (CH_WIDTH+1)'(NUM_CHANNELS));
  assign wr     = adv && s1_v_q && !s1_stale_q && !flush;

  always_comb begin
    len_c   = CW'(1) << s1_k_q;
    mask_c  = PW'(len_c - CW'(1));
    full_b  = (s1_cnt_q >= len_c);
    x_ext   = ACC_WIDTH'(s1_x_q);
    old_ext = ACC_WIDTH'(s1_old_q);
    acc_new = full_b ? (s1_acc_q - old_ext + x_ext) : (s1_acc_q + x_ext);
    ptr_new = (s1_ptr_q + PW'(1)) & mask_c;
    cnt_new = full_b ? len_c : (s1_cnt_q + CW'(1));
    rnd_w   = '0;
    if (ROUND != 0 && s1_k_q != '0)
      rnd_w = (ACC_WIDTH+1)'(1) << (s1_k_q - LW'(1));
    // one extra bit so the rounding offset cannot wrap the sum
    avg_w = ((ACC_WIDTH+1)'(acc_new) + rnd_w) >>> s1_k_q;
    if (avg_w > (ACC_WIDTH+1)'(DMAX))
      avg_sat = DATA_WIDTH'(DMAX);
    else if (avg_w < (ACC_WIDTH+1)'(DMIN))
      avg_sat = DATA_WIDTH'(DMIN);
    else
      avg_sat = avg_w[DATA_WIDTH-1:0];
  end

  // same-channel sample committing this edge feeds its new state forward
  always_comb begin
    fwd    = s1_v_q && !s1_stale_q && (s1_ch_q == s0_ch_q);
    rd_acc = fwd ? acc_new : acc_q[s0_ch_q];
    rd_ptr = fwd ? ptr_new : ptr_q[s0_ch_q];
    rd_cnt = fwd ? cnt_new : cnt_q[s0_ch_q];
    rd_old = (fwd && rd_ptr == s1_ptr_q) ?
             s1_x_q : mem_q[s0_ch_q][rd_ptr];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s0_v_q     <= 1'b0;
      s0_ch_q    <= '0;
      s0_x_q     <= '0;
      s1_v_q     <= 1'b0;
      s1_stale_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_x_q     <= '0;
      s1_old_q   <= '0;
      s1_acc_q   <= '0;
      s1_ptr_q   <= '0;
      s1_cnt_q   <= '0;
      s1_k_q     <= '0;
      ov_q       <= 1'b0;
      och_q      <= '0;
      osum_q     <= '0;
      odata_q    <= '0;
      ofull_q    <= 1'b0;
    end else if (adv) begin
      s0_v_q <= accept && ch_ok;
      if (accept) begin
        s0_ch_q <= i_channel;
        s0_x_q  <= i_data;
      end
      s1_v_q     <= s0_v_q;
      s1_stale_q <= flush;
      s1_ch_q    <= s0_ch_q;
      s1_x_q     <= s0_x_q;
      s1_old_q   <= rd_old;
      s1_acc_q   <= rd_acc;
      s1_ptr_q   <= rd_ptr;
      s1_cnt_q   <= rd_cnt;
      s1_k_q     <= k_q;
      ov_q       <= s1_v_q;
      if (s1_v_q) begin
        och_q   <= s1_ch_q;
        osum_q  <= acc_new;
        odata_q <= avg_sat;
        ofull_q <= (cnt_new == len_c);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      k_q <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        acc_q[c] <= '0;
        ptr_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else if (flush && adv) begin
      k_q <= k_sat;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        acc_q[c] <= '0;
        ptr_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else if (wr) begin
      acc_q[s1_ch_q] <= acc_new;
      ptr_q[s1_ch_q] <= ptr_new;
      cnt_q[s1_ch_q] <= cnt_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr)
      mem_q[s1_ch_q][s1_ptr_q] <= s1_x_q;
  end

  assign o_valid   = ov_q;
  assign o_channel = och_q;
  assign o_sum     = osum_q;
  assign o_data    = odata_q;
  assign o_full    = ofull_q;

endmodule

// File: tb/tb_moving_average_mc.sv
// tb_moving_average_mc: directed vectors with hand-computed sums/averages.
// Outputs are captured at negedge on each handshake and checked in order.
module tb_moving_average_mc;
  localparam int DW = 8;
  localparam int AW = 11;
  localparam int LW = 2;

  typedef struct {
    int s;
    int d;
    bit f;
    int c;
  } out_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [LW-1:0]        log2_len = '0;
  logic                 clr = 1'b0;
  logic                 in_v = 1'b0;
  logic                 out_rdy = 1'b1;
  logic [0:0]           in_ch = '0;
  logic signed [DW-1:0] in_d = '0;
  logic                 o_ready, o_valid, o_full;
  logic [0:0]           o_channel;
  logic signed [AW-1:0] o_sum;
  logic signed [DW-1:0] o_data;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  out_t q_out[$];
  int   q_acc[$];
  int   bp_s [6] = '{1, 3, 6, 10, 15, 21};
  int   bp_d [6] = '{0, 0, 1, 1, 2, 3};

  moving_average_mc dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_log2_len (log2_len),
    .i_clear    (clr),
    .i_valid    (in_v),
    .o_ready    (o_ready),
    .i_channel  (in_ch),
    .i_data     (in_d),
    .o_valid    (o_valid),
    .i_ready    (out_rdy),
    .o_channel  (o_channel),
    .o_sum      (o_sum),
    .o_data     (o_data),
    .o_full     (o_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && o_valid && out_rdy)
      q_out.push_back('{int'(o_sum), int'(o_data), o_full, cyc});
  end

  task automatic check(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [0:0] ch, input int x);
    int n = 0;
    in_v  = 1'b1;
    in_ch = ch;
    in_d  = DW'(x);
    @(negedge clk);
    while (!o_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("send_ready", o_ready, 1);
    q_acc.push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_v = 1'b0;
  endtask

  task automatic wait_outs(input string tag, input int n);
    int t = 0;
    while (q_out.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_count"}, q_out.size(), n);
  endtask

  task automatic expect_out(input string tag, input int s, input int d,
                            input bit f, input bit lat);
    out_t o;
    int   a;
    if (q_out.size() == 0 || q_acc.size() == 0) begin
      check({tag, "_present"}, q_out.size(), 1);
      return;
    end
    o = q_out.pop_front();
    a = q_acc.pop_front();
    check({tag, "_sum"}, o.s, s);
    check({tag, "_data"}, o.d, d);
    check({tag, "_full"}, o.f, f);
    if (lat)
      check({tag, "_lat"}, o.c - a, 2);
  endtask

  task automatic drop_out();
    if (q_out.size() > 0) void'(q_out.pop_front());
    if (q_acc.size() > 0) void'(q_acc.pop_front());
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_sum", o_sum, 0);
    check("rst_data", o_data, 0);
    check("rst_full", o_full, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", o_ready, 1);
    check("idle_valid", o_valid, 0);

    // k = 2, single channel
    step();
    log2_len = 2;
    @(negedge clk);
    check("k2_flush_rdy", o_ready, 0);
    @(negedge clk);
    check("k2_after_rdy", o_ready, 1);
    step();
    send(0, 4);
    send(0, 8);
    send(0, 12);
    send(0, 16);
    send(0, 20);
    wait_outs("k2", 5);
    expect_out("k2_0", 4, 1, 0, 1);
    expect_out("k2_1", 12, 3, 0, 1);
    expect_out("k2_2", 24, 6, 0, 1);
    expect_out("k2_3", 40, 10, 1, 1);
    expect_out("k2_4", 56, 14, 1, 1);

    // k = 1, interleaved back-to-back
    step();
    log2_len = 1;
    step();
    q_out.delete();
    q_acc.delete();
    send(0, 10);
    send(0, 10);
    send(1, -5);
    send(0, 2);
    wait_outs("k1", 4);
    expect_out("k1_0", 10, 5, 0, 1);
    expect_out("k1_1", 20, 10, 1, 1);
    expect_out("k1_2", -5, -2, 0, 1);
    expect_out("k1_3", 12, 6, 1, 1);

    // k = 3, extreme values on ch1
    step();
    log2_len = 3;
    step();
    q_out.delete();
    q_acc.delete();
    for (int i = 0; i < 8; i++) send(1, -128);
    for (int i = 0; i < 8; i++) send(1, 127);
    wait_outs("k3", 16);
    for (int i = 0; i < 16; i++) begin
      if (i == 0)
        expect_out("k3_first", -128, -16, 0, 0);
      else if (i == 7)
        expect_out("k3_neg", -1024, -128, 1, 0);
      else if (i == 8)
        expect_out("k3_mix", -769, -96, 1, 0);
      else if (i == 15)
        expect_out("k3_pos", 1016, 127, 1, 0);
      else
        drop_out();
    end

    // clear, then backpressure for 5 cycles
    step();
    clr = 1'b1;
    @(negedge clk);
    check("clr_rdy", o_ready, 0);
    step();
    clr = 1'b0;
    q_out.delete();
    q_acc.delete();
    fork
      begin
        for (int v = 1; v <= 6; v++) send(0, v);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_hold_valid", o_valid, 1);
          if (q_out.size() < 6) begin
            check("bp_hold_sum", o_sum, bp_s[q_out.size()]);
            check("bp_hold_data", o_data, bp_d[q_out.size()]);
          end
        end
        check("bp_rdy_low", o_ready, 0);
        step();
        out_rdy = 1'b1;
      end
    join
    wait_outs("bp", 6);
    for (int i = 0; i < 6; i++)
      expect_out("bp", bp_s[i], bp_d[i], 0, 0);
    @(negedge clk);
    check("bp_no_dup", q_out.size(), 0);

    // window change mid-stream: in-flight samples keep k = 2
    step();
    log2_len = 2;
    step();
    q_out.delete();
    q_acc.delete();
    send(0, 5);
    send(0, 7);
    log2_len = 1;
    @(negedge clk);
    check("kchg_rdy_low", o_ready, 0);
    @(negedge clk);
    check("kchg_rdy_high", o_ready, 1);
    step();
    send(0, 6);
    send(0, 6);
    wait_outs("kchg", 4);
    expect_out("kchg_old0", 5, 1, 0, 0);
    expect_out("kchg_old1", 12, 3, 0, 0);
    expect_out("kchg_new0", 6, 3, 0, 0);
    expect_out("kchg_new1", 12, 6, 1, 0);

    // asynchronous reset while outputs are in flight
    step();
    send(0, 1);
    send(0, 2);
    send(0, 3);
    check("prerst_valid", o_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_sum", o_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_valid", o_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
